// File: rtl/pulse_train_gen.sv
// Programmable pulse-train generator: periodic, one-shot and burst modes with
// retrigger, synchronous abort and a count-enable that freezes the train.
module pulse_train_gen #(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned BURST_W = 8,
  parameter int unsigned PW      = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               ena,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [CNT_W-1:0]   period,
  input  logic [BURST_W-1:0] burst_len,
  output logic               out,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [1:0] ModePeriodic = 2'b00;
  localparam logic [1:0] ModeBurst    = 2'b10;

  localparam logic [CNT_W-1:0]   PwCnt    = CNT_W'(PW);
  localparam logic [CNT_W-1:0]   CntOne   = CNT_W'(1);
  localparam logic [BURST_W-1:0] BurstOne = BURST_W'(1);

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [BURST_W-1:0]   pcnt_q, pcnt_d;
  logic [CNT_W-1:0]     p_q, p_d;
  logic [BURST_W-1:0]   b_q, b_d;
  logic [1:0]           mode_q, mode_d;

  logic                 period_end;
  logic                 last_period;
  logic [BURST_W-1:0]   pcnt_inc;

  assign period_end = (cnt_q == (p_q - CntOne));
  assign pcnt_inc   = pcnt_q + BurstOne;

  // Mode 11 is reserved and behaves exactly like one-shot.
  always_comb begin
    last_period = 1'b0;
    if (mode_q == ModeBurst) begin
      last_period = (pcnt_inc == b_q);
    end else if (mode_q != ModePeriodic) begin
      last_period = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pcnt_d  = pcnt_q;
    p_d     = p_q;
    b_d     = b_q;
    mode_d  = mode_q;

    if (clear) begin
      state_d = StIdle;
      cnt_d   = '0;
      pcnt_d  = '0;
    end else if (start) begin
      // Launch and retrigger are identical, and win over any period end.
      state_d = StRun;
      cnt_d   = '0;
      pcnt_d  = '0;
      p_d     = (period == '0) ? CntOne : period;
      b_d     = (burst_len == '0) ? BurstOne : burst_len;
      mode_d  = mode;
    end else begin
      unique case (state_q)
        StIdle: begin
          state_d = StIdle;
        end
        StRun: begin
          if (ena) begin
            if (period_end) begin
              cnt_d  = '0;
              pcnt_d = pcnt_inc;
              if (last_period) begin
                state_d = StDone;
              end
            end else begin
              cnt_d = cnt_q + CntOne;
            end
          end
        end
        StDone: begin
          state_d = StIdle;
          cnt_d   = '0;
          pcnt_d  = '0;
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
          pcnt_d  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      pcnt_q  <= '0;
      p_q     <= CntOne;
      b_q     <= BurstOne;
      mode_q  <= ModePeriodic;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pcnt_q  <= pcnt_d;
      p_q     <= p_d;
      b_q     <= b_d;
      mode_q  <= mode_d;
    end
  end

  assign busy = (state_q == StRun);
  assign done = (state_q == StDone);
  assign out  = busy && ena && (cnt_q < PwCnt);

endmodule

// File: tb/tb_pulse_train_gen.sv
// Bench for pulse_train_gen: an elapsed-clock model checked every cycle, plus
// per-scenario literal waveforms captured as bit vectors indexed by cycle.
module tb_pulse_train_gen;

  localparam int unsigned CNT_W   = 8;
  localparam int unsigned BURST_W = 4;
  localparam int unsigned PW      = 2;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               ena;
  logic               start;
  logic [1:0]         mode;
  logic [CNT_W-1:0]   period;
  logic [BURST_W-1:0] burst_len;
  logic               out;
  logic               busy;
  logic               done;

  pulse_train_gen #(
    .CNT_W  (CNT_W),
    .BURST_W(BURST_W),
    .PW     (PW)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .ena      (ena),
    .start    (start),
    .mode     (mode),
    .period   (period),
    .burst_len(burst_len),
    .out      (out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [31:0] out_v, busy_v, done_v;

  // Model: a run is "elapsed enabled clocks since start"; completion happens
  // once elapsed reaches periods_needed * P.
  bit m_active = 1'b0;
  bit m_done   = 1'b0;
  int m_el     = 0;
  int m_p      = 1;
  int m_b      = 1;
  int m_mode   = 0;

  function automatic int periods_needed(input int md, input int b);
    if (md == 0) return 0;
    if (md == 2) return b;
    return 1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_el     <= 0;
      m_p      <= 1;
      m_b      <= 1;
      m_mode   <= 0;
    end else if (clear) begin
      m_active <= 1'b0;
      m_done   <= 1'b0;
      m_el     <= 0;
    end else if (start) begin
      m_active <= 1'b1;
      m_done   <= 1'b0;
      m_el     <= 0;
      m_p      <= (period == 0) ? 1 : int'(period);
      m_b      <= (burst_len == 0) ? 1 : int'(burst_len);
      m_mode   <= int'(mode);
    end else begin
      m_done <= 1'b0;
      if (m_active && ena) begin
        m_el <= m_el + 1;
        if (m_mode != 0 && (m_el + 1) == m_p * periods_needed(m_mode, m_b)) begin
          m_active <= 1'b0;
          m_done   <= 1'b1;
        end
      end
    end
  end

  task automatic check_cycle();
    logic [2:0] exp_v, act_v;
    exp_v[2] = m_active && ena && ((m_el % m_p) < int'(PW));
    exp_v[1] = m_active;
    exp_v[0] = m_done;
    act_v    = {out, busy, done};
    vectors++;
    if (act_v !== exp_v) begin
      miscompares++;
      $display("FAIL model t=%0t cyc=%0d {out,busy,done} got %b expected %b",
               $time, cyc, act_v, exp_v);
    end
    if (cyc < 32) begin
      out_v[cyc]  = out;
      busy_v[cyc] = busy;
      done_v[cyc] = done;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  task automatic begin_scn();
    cyc    = 0;
    out_v  = '0;
    busy_v = '0;
    done_v = '0;
  endtask

  // Runs n cycles; start at cycles s0/s1, clear at clr, ena low over elo..ehi.
  // Config inputs are scrambled outside start cycles to show they are ignored.
  task automatic run(input int n, input logic [1:0] md, input int p, input int b,
                     input int s0, input int s1, input int clr, input int elo,
                     input int ehi);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    begin_scn();
    for (int c = 0; c < n; c++) begin
      start = (c == s0) || (c == s1);
      clear = (c == clr);
      ena   = !(c >= elo && c <= ehi);
      if (start) begin
        mode      = md;
        period    = CNT_W'(p);
        burst_len = BURST_W'(b);
      end else begin
        mode      = md ^ 2'b11;
        period    = CNT_W'(p + 7);
        burst_len = BURST_W'(b + 5);
      end
      tick();
    end
    start = 1'b0;
    clear = 1'b0;
    ena   = 1'b1;
  endtask

  initial begin
    rst       = 1'b1;
    clear     = 1'b0;
    ena       = 1'b1;
    start     = 1'b0;
    mode      = 2'b00;
    period    = '0;
    burst_len = '0;
    begin_scn();
    tick();
    tick();
    chk("reset_outputs", {29'd0, out, busy, done}, 32'd0);
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      ena = c[0];
      tick();
    end
    chk("idle_after_reset", busy_v | done_v | out_v, 32'd0);
    ena = 1'b1;

    run(16, 2'b00, 5, 0, 0, -1, -1, -1, -2);
    chk("periodic_out", out_v & 32'hFFFF, 32'h18C6);
    chk("periodic_busy", busy_v & 32'hFFFF, 32'hFFFE);
    chk("periodic_done", done_v & 32'hFFFF, 32'h0000);

    run(16, 2'b01, 4, 0, 0, -1, -1, -1, -2);
    chk("oneshot_out", out_v & 32'hFFFF, 32'h0006);
    chk("oneshot_busy", busy_v & 32'hFFFF, 32'h001E);
    chk("oneshot_done", done_v & 32'hFFFF, 32'h0020);

    run(16, 2'b11, 4, 0, 0, -1, -1, -1, -2);
    chk("mode11_out", out_v & 32'hFFFF, 32'h0006);
    chk("mode11_done", done_v & 32'hFFFF, 32'h0020);

    run(16, 2'b10, 3, 3, 0, -1, -1, -1, -2);
    chk("burst_out", out_v & 32'hFFFF, 32'h01B6);
    chk("burst_busy", busy_v & 32'hFFFF, 32'h03FE);
    chk("burst_done", done_v & 32'hFFFF, 32'h0400);

    run(16, 2'b00, 5, 0, 0, -1, -1, 3, 5);
    chk("ena_gap_out", out_v & 32'h1FFF, 32'h0606);

    run(16, 2'b10, 3, 3, 0, -1, 4, -1, -2);
    chk("clear_out", out_v & 32'hFFFF, 32'h0016);
    chk("clear_busy", busy_v & 32'hFFFF, 32'h001E);
    chk("clear_done", done_v & 32'hFFFF, 32'h0000);

    run(16, 2'b10, 3, 3, 0, -1, -1, -1, -2);
    chk("burst_again_out", out_v & 32'hFFFF, 32'h01B6);
    chk("burst_again_done", done_v & 32'hFFFF, 32'h0400);

    run(16, 2'b01, 4, 0, 0, 4, -1, -1, -2);
    chk("retrig_out", out_v & 32'hFFFF, 32'h0066);
    chk("retrig_busy", busy_v & 32'hFFFF, 32'h01FE);
    chk("retrig_done", done_v & 32'hFFFF, 32'h0200);

    run(10, 2'b01, 2, 0, 0, 3, -1, -1, -2);
    chk("start_in_done_busy", busy_v & 32'hFF, 32'h36);
    chk("start_in_done_done", done_v & 32'hFF, 32'h48);

    run(12, 2'b10, 3, 0, 0, -1, -1, -1, -2);
    chk("burst_len0_done", done_v & 32'hFFF, 32'h010);

    run(8, 2'b00, 5, 0, 0, -1, -1, 0, 0);
    chk("ena_low_launch_busy", busy_v & 32'hF, 32'hE);

    run(6, 2'b10, 3, 3, 0, -1, 3, -1, -2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    chk("clear_in_done", {31'd0, done}, 32'd0);

    // Asynchronous reset mid-cycle while out is high.
    run(2, 2'b00, 5, 0, 0, -1, -1, -1, -2);
    chk("pre_rst_out", {31'd0, out}, 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_outputs", {29'd0, out, busy, done}, 32'd0);
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_idle", {30'd0, busy, done}, 32'd0);

    run(12, 2'b00, 0, 0, 0, -1, -1, -1, -2);
    chk("period0_out", (out_v >> 1) & 32'h3FF, 32'h3FF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pulse_train_gen.md
PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 The block SHALL provide parameter CNT_W, default 16, setting the width of the period counter and the period input.
REQ-002 The block SHALL provide parameter BURST_W, default 8, setting the width of the burst-length input and the pulse counter.
REQ-003 The block SHALL provide parameter PW, default 1, setting the pulse high time in clocks; legal range is 1 to 2^CNT_W-1.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 clear  input  1  synchronous abort; returns the block to IDLE.
REQ-007 ena  input  1  count enable; low freezes the generator.
REQ-008 start  input  1  launch or retrigger request, sampled on each clock.
REQ-009 mode  input  2  00 periodic, 01 one-shot, 10 burst, 11 reserved and treated as one-shot.
REQ-010 period  input  CNT_W  period length in clocks; latched at start.
REQ-011 burst_len  input  BURST_W  number of periods in burst mode; latched at start.
REQ-012 out  output  1  pulse train.
REQ-013 busy  output  1  high while in RUN.
REQ-014 done  output  1  one-clock completion strobe.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-016 Per-clock priority SHALL be: clear, then start, then ena.
REQ-017 In IDLE, start=1 SHALL enter RUN on the next edge, clearing cnt and pulse count and latching P, B and mode.
REQ-018 P SHALL equal period, with period=0 latched as 1.
REQ-019 B SHALL equal burst_len, with burst_len=0 latched as 1.
REQ-020 The ena input SHALL have no effect on leaving IDLE.
REQ-021 In RUN with ena=1, cnt SHALL count 0 to P-1 and then wrap to 0.
REQ-022 Each wrap of cnt SHALL complete one period and increment the pulse count.
REQ-023 Counter arithmetic SHALL be unsigned modulo the counter width.
REQ-024 out SHALL be combinational and equal (state==RUN and ena and cnt<PW).
REQ-025 If P<=PW, out SHALL stay high for the whole RUN time whenever ena is high.
REQ-026 In RUN with ena=0, cnt, pulse count and state SHALL hold and out SHALL be 0; counting resumes from the held cnt when ena returns high.
REQ-027 Periodic mode SHALL stay in RUN indefinitely until clear, rst or a retrigger.
REQ-028 One-shot mode SHALL go RUN to DONE at the end of the first period.
REQ-029 Burst mode SHALL go RUN to DONE at the end of period B.
REQ-030 DONE SHALL last exactly one clock and then go to IDLE.
REQ-031 start=1 in DONE SHALL go directly to RUN instead of IDLE.
REQ-032 start=1 in RUN SHALL retrigger the block: cnt and pulse count return to 0 and P, B and mode are relatched.
REQ-033 A retrigger SHALL take priority over a period end or completion in the same clock; no done is produced.
REQ-034 busy SHALL equal (state==RUN).
REQ-035 done SHALL equal (state==DONE).
REQ-036 Latency from a sampled start to the first out high SHALL be one clock.
REQ-037 clear=1 SHALL force IDLE and zero both counters on the next edge without asserting done, including when clear is asserted in DONE.
REQ-038 Changes to period, burst_len or mode while in RUN SHALL have no effect until the next start.

Reset
REQ-039 rst=1 SHALL immediately, without a clock edge, force state IDLE and cnt=0, pulse count=0, latched P=1, B=1, mode=00.
REQ-040 While rst=1, out, busy and done SHALL all be 0.
REQ-041 After rst is released, the block SHALL stay idle until the next sampled start.

Verification
Bench parameters: CNT_W=8, BURST_W=4, PW=2; ena=1 unless stated; start sampled at cycle 0.
REQ-042 Periodic, period=5 -> out high at cycles 1-2, 6-7, 11-12 and so on; busy high from cycle 1; done never asserts.
REQ-043 One-shot, period=4 -> out high at cycles 1-2; done=1 at cycle 5 only; busy low from cycle 5.
REQ-044 Burst, period=3, burst_len=3 -> out high at cycles 1-2, 4-5, 7-8; done=1 at cycle 10.
REQ-045 Periodic, period=5, ena=0 during cycles 3-5 -> out low at cycles 3-5; next out high at cycles 9-10.
REQ-046 Burst running, clear=1 at cycle 4 -> busy=0 and out=0 from cycle 5; done never asserts; a new start then behaves as in REQ-044.
REQ-047 rst=1 asserted mid-cycle while out=1 -> out and busy fall before the next clock edge; period=0 then start gives out=1 on every clock.
